// File: rtl/handshake_cond_br_buf_pkg.sv
// Shared constants and helpers for the conditional branch buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package handshake_cond_br_buf_pkg;

    // The join merges exactly two tokens: condition and data.
    localparam int JOIN_SIZE = 2;

    // Occupancy update for a FIFO that may push and pop in the same cycle.
    // A simultaneous push and pop leaves the count unchanged.
    function automatic logic [1:0] count_upd(input logic [1:0] cnt,
                                             input logic       push,
                                             input logic       pop);
        logic [1:0] res;
        res = cnt;
        if (push && !pop) begin
            res = cnt + 2'd1;
        end else if (pop && !push) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/handshake_cond_br_buf_join.sv
// Join of SIZE valid/ready inputs into one output token.
// Latency: 0 cycles (purely combinational).
// Backpressure: each input is ready only when the output is ready and all other inputs are valid.
// Ports: ins_valid/ins_ready per input, outs_valid/outs_ready for the joined token.
module join_type #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] ins_valid,
    input  logic            outs_ready,
    output logic [SIZE-1:0] ins_ready,
    output logic            outs_valid
);

    always_comb begin
        outs_valid = &ins_valid;
        ins_ready  = '0;
        for (int i = 0; i < SIZE; i++) begin
            ins_ready[i] = outs_ready;
            for (int j = 0; j < SIZE; j++) begin
                if (j != i) begin
                    ins_ready[i] = ins_ready[i] & ins_valid[j];
                end
            end
        end
    end

endmodule

// File: rtl/handshake_cond_br_buf.sv
// Conditional branch with a 2-entry buffer: joins {condition, data} and steers data to the true or false output.
// Latency: 1 cycle from push to output valid; sustains 1 token/cycle.
// Backpressure: input readies depend only on FIFO fullness, never on output readies.
// Ports: condition/data (+valid/ready) in; trueOut/falseOut (+valid/ready) out; clk, rst (async, active-low).
module handshake_cond_br_buf
    import handshake_cond_br_buf_pkg::*;
#(
    parameter int DATA_TYPE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 condition,
    input  logic                 condition_valid,
    input  logic [DATA_TYPE-1:0] data,
    input  logic                 data_valid,
    input  logic                 trueOut_ready,
    input  logic                 falseOut_ready,
    output logic                 condition_ready,
    output logic                 data_ready,
    output logic [DATA_TYPE-1:0] trueOut,
    output logic                 trueOut_valid,
    output logic [DATA_TYPE-1:0] falseOut,
    output logic                 falseOut_valid
);

    localparam int DEPTH = 2;

    logic [DATA_TYPE-1:0] data_mem_q [DEPTH];
    logic [DATA_TYPE-1:0] data_mem_d [DEPTH];
    logic [DEPTH-1:0]     cond_mem_q;
    logic [DEPTH-1:0]     cond_mem_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;

    logic                 full;
    logic                 joined_vld;
    logic [JOIN_SIZE-1:0] join_rdy;
    logic                 push;
    logic                 pop;
    logic                 head_cond;
    logic                 not_empty;

    // Fullness comes from registered state only, so no ready path runs
    // combinationally from the outputs back to the inputs.
    assign full = (count_q == 2'(DEPTH));

    join_type #(
        .SIZE(JOIN_SIZE)
    ) u_join (
        .ins_valid  ({data_valid, condition_valid}),
        .outs_ready (~full),
        .ins_ready  (join_rdy),
        .outs_valid (joined_vld)
    );

    assign condition_ready = join_rdy[0];
    assign data_ready      = join_rdy[1];

    assign not_empty = (count_q != 2'd0);
    assign head_cond = cond_mem_q[rd_ptr_q];

    assign trueOut_valid  = not_empty & head_cond;
    assign falseOut_valid = not_empty & ~head_cond;
    assign trueOut        = data_mem_q[rd_ptr_q];
    assign falseOut       = data_mem_q[rd_ptr_q];

    assign push = joined_vld & ~full;
    // Only the ready of the side currently selected by the head matters.
    assign pop  = (trueOut_valid & trueOut_ready) | (falseOut_valid & falseOut_ready);

    always_comb begin
        data_mem_d = data_mem_q;
        cond_mem_d = cond_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            data_mem_d[wr_ptr_q] = data;
            cond_mem_d[wr_ptr_q] = condition;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_upd(count_q, push, pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
            end
            cond_mem_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            data_mem_q <= data_mem_d;
            cond_mem_q <= cond_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_handshake_cond_br_buf.sv
module tb_handshake_cond_br_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        condition = 1'b0;
    logic        condition_valid = 1'b0;
    logic [31:0] data = '0;
    logic        data_valid = 1'b0;
    logic        trueOut_ready = 1'b0;
    logic        falseOut_ready = 1'b0;
    logic        condition_ready;
    logic        data_ready;
    logic [31:0] trueOut;
    logic        trueOut_valid;
    logic [31:0] falseOut;
    logic        falseOut_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of {condition, data} tokens held by the buffer.
    logic [32:0] q[$];
    bit          last_push;
    bit          last_pop;

    handshake_cond_br_buf #(.DATA_TYPE(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .condition       (condition),
        .condition_valid (condition_valid),
        .data            (data),
        .data_valid      (data_valid),
        .trueOut_ready   (trueOut_ready),
        .falseOut_ready  (falseOut_ready),
        .condition_ready (condition_ready),
        .data_ready      (data_ready),
        .trueOut         (trueOut),
        .trueOut_valid   (trueOut_valid),
        .falseOut        (falseOut),
        .falseOut_valid  (falseOut_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output against the model at the falling edge, then advance
    // one rising edge and apply the model's push/pop rules.
    task automatic step();
        logic [32:0] h;
        bit push, pop;
        @(negedge clk);
        chk("condition_ready", condition_ready, 32'(data_valid && q.size() < 2));
        chk("data_ready", data_ready, 32'(condition_valid && q.size() < 2));
        if (q.size() > 0) begin
            h = q[0];
            chk("trueOut_valid", trueOut_valid, 32'(h[32]));
            chk("falseOut_valid", falseOut_valid, 32'(!h[32]));
            chk("trueOut", trueOut, h[31:0]);
            chk("falseOut", falseOut, h[31:0]);
        end else begin
            chk("trueOut_valid_empty", trueOut_valid, 32'd0);
            chk("falseOut_valid_empty", falseOut_valid, 32'd0);
        end
        push = rst && condition_valid && data_valid && (q.size() < 2);
        pop  = rst && (q.size() > 0) && (q[0][32] ? trueOut_ready : falseOut_ready);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back({condition, data});
        last_push = push;
        last_pop  = pop;
    endtask

    // Offer one pair and wait (bounded) until it is accepted.
    task automatic send(input logic c, input logic [31:0] d);
        condition       = c;
        data            = d;
        condition_valid = 1'b1;
        data_valid      = 1'b1;
        last_push       = 1'b0;
        for (int n = 0; n < 20 && !last_push; n++) step();
        chk("send_accepted", 32'(last_push), 32'd1);
        condition_valid = 1'b0;
        data_valid      = 1'b0;
    endtask

    initial begin
        // Reset state, readies follow the opposite valid while empty.
        data_valid = 1'b1;
        #2;
        chk("rst_trueOut_valid", trueOut_valid, 32'd0);
        chk("rst_falseOut_valid", falseOut_valid, 32'd0);
        chk("rst_trueOut", trueOut, 32'd0);
        chk("rst_falseOut", falseOut, 32'd0);
        chk("rst_condition_ready", condition_ready, 32'd1);
        chk("rst_data_ready", data_ready, 32'd0);
        data_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        step();

        // Single true token, popped on the cycle it appears.
        trueOut_ready = 1'b1;
        send(1'b1, 32'h0000_00AA);
        chk("req033_tv", trueOut_valid, 32'd1);
        chk("req033_data", trueOut, 32'hAA);
        chk("req033_fv", falseOut_valid, 32'd0);
        step();
        chk("req033_popped", 32'(last_pop), 32'd1);
        trueOut_ready = 1'b0;

        // Condition waits alone: nothing pushed, its ready stays low.
        condition       = 1'b0;
        condition_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("req034_no_push", 32'(last_push), 32'd0);
        end
        send(1'b0, 32'd5);
        chk("req034_fv", falseOut_valid, 32'd1);
        chk("req034_data", falseOut, 32'd5);
        falseOut_ready = 1'b1;
        step();

        // Fill to two entries with outputs stalled; third pair must wait.
        trueOut_ready  = 1'b0;
        falseOut_ready = 1'b0;
        send(1'b1, 32'd1);
        send(1'b0, 32'd2);
        condition = 1'b1; data = 32'd3; condition_valid = 1'b1; data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("req035_held", 32'(last_push), 32'd0);
        end
        trueOut_ready  = 1'b1;
        falseOut_ready = 1'b1;
        send(1'b1, 32'd3);
        for (int i = 0; i < 3; i++) step();
        chk("req035_drained", 32'(q.size()), 32'd0);

        // Alternating sides at full rate.
        for (int i = 0; i < 8; i++) begin
            condition = i[0]; data = 32'h100 + i; condition_valid = 1'b1; data_valid = 1'b1;
            step();
            chk("req036_push", 32'(last_push), 32'd1);
            if (i > 0) chk("req036_pop", 32'(last_pop), 32'd1);
        end
        condition_valid = 1'b0; data_valid = 1'b0;
        step();

        // Head on true side, only the wrong side ready: no pop.
        trueOut_ready = 1'b0; falseOut_ready = 1'b1;
        send(1'b1, 32'hBEEF);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("req037_no_pop", 32'(last_pop), 32'd0);
            chk("req037_stable", trueOut, 32'hBEEF);
        end

        // Fill, then reset asynchronously between edges.
        send(1'b0, 32'h22);
        chk("req038_full", 32'(q.size()), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("req038_tv_async", trueOut_valid, 32'd0);
        chk("req038_fv_async", falseOut_valid, 32'd0);
        chk("req038_data_async", trueOut, 32'd0);
        q.delete();
        step();
        rst = 1'b1;
        trueOut_ready = 1'b1;
        send(1'b1, 32'h77);
        chk("req038_post", trueOut, 32'h77);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            condition       = 1'($urandom_range(0, 1));
            condition_valid = 1'($urandom_range(0, 1));
            data_valid      = 1'($urandom_range(0, 1));
            data            = $urandom;
            trueOut_ready   = 1'($urandom_range(0, 1));
            falseOut_ready  = 1'($urandom_range(0, 1));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
